// File: rtl/sys_arr_sched.sv
// Tile scheduler for the block-matrix-multiply systolic array.
// For each tile it pulls N weight vectors, then M activation vectors, and merges
// them into one registered vector stream tagged with type and last. After the
// final tile it waits a fixed drain time, then pulses done.
// sched_data_out layout (MSB..LSB): {data_vect_words, data_vect_val, data_vect_type, data_vect_last}
module sys_arr_sched #(
  parameter int   VECT_SIZE      = 4,
  parameter int   ARITH_WORD_LEN = 8,
  parameter int   ACT_LEN_WDT    = 16,
  parameter int   DRAIN_CYC      = 32,
  parameter logic TYPE_W         = 1'b1,
  parameter logic TYPE_X         = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clk_en,
  input  logic                                  start,
  input  logic [ACT_LEN_WDT-1:0]                cfg_act_len,
  input  logic [ACT_LEN_WDT-1:0]                cfg_tile_cnt,
  input  logic [VECT_SIZE*ARITH_WORD_LEN-1:0]   w_words,
  input  logic                                  w_val,
  output logic                                  w_rdy,
  input  logic [VECT_SIZE*ARITH_WORD_LEN-1:0]   x_words,
  input  logic                                  x_val,
  output logic                                  x_rdy,
  output logic [VECT_SIZE*ARITH_WORD_LEN+2:0]   sched_data_out,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  cfg_err
);

  localparam int WORDS_W = VECT_SIZE * ARITH_WORD_LEN;
  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

  localparam logic [ACT_LEN_WDT-1:0] N_LAST     = ACT_LEN_WDT'(VECT_SIZE - 1);
  localparam logic [ACT_LEN_WDT-1:0] CNT_ONE    = ACT_LEN_WDT'(1);
  localparam logic [DRAIN_W-1:0]     DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [DRAIN_W-1:0]     DRAIN_ONE  = DRAIN_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_W   = 2'd1,
    STREAM_X = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ACT_LEN_WDT-1:0] act_len_q;
  logic [ACT_LEN_WDT-1:0] tile_cfg_q;
  logic [ACT_LEN_WDT-1:0] beat_cnt;
  logic [ACT_LEN_WDT-1:0] tile_cnt;
  logic [DRAIN_W-1:0]     drain_cnt;

  logic [WORDS_W-1:0] out_words;
  logic               out_val;
  logic               out_type;
  logic               out_last;

  logic start_ok;
  logic w_fire;
  logic x_fire;
  logic beat_last;
  logic tile_last;

  // State register; holds whenever the global clock enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus handshake, completion and error strobes, all gated by clk_en.
  always_comb begin
    state_nxt = state;
    w_rdy     = 1'b0;
    x_rdy     = 1'b0;
    done      = 1'b0;
    cfg_err   = 1'b0;
    start_ok  = 1'b0;
    w_fire    = 1'b0;
    x_fire    = 1'b0;
    beat_last = 1'b0;
    tile_last = 1'b0;
    case (state)
      IDLE: begin
        if (clk_en && start) begin
          if ((cfg_act_len != '0) && (cfg_tile_cnt != '0)) begin
            start_ok  = 1'b1;
            state_nxt = LOAD_W;
          end else begin
            cfg_err = 1'b1;
          end
        end
      end
      LOAD_W: begin
        w_rdy     = clk_en;
        w_fire    = w_val && clk_en;
        beat_last = (beat_cnt == N_LAST);
        if (w_fire && beat_last) begin
          state_nxt = STREAM_X;
        end
      end
      STREAM_X: begin
        x_rdy     = clk_en;
        x_fire    = x_val && clk_en;
        beat_last = (beat_cnt == (act_len_q - CNT_ONE));
        tile_last = (tile_cnt == (tile_cfg_q - CNT_ONE));
        if (x_fire && beat_last) begin
          state_nxt = tile_last ? DRAIN : LOAD_W;
        end
      end
      DRAIN: begin
        if (clk_en && (drain_cnt == DRAIN_LAST)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latch the run configuration at start and step the beat, tile and drain counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_len_q  <= '0;
      tile_cfg_q <= '0;
      beat_cnt   <= '0;
      tile_cnt   <= '0;
      drain_cnt  <= '0;
    end else if (clk_en) begin
      if (start_ok) begin
        act_len_q  <= cfg_act_len;
        tile_cfg_q <= cfg_tile_cnt;
        beat_cnt   <= '0;
        tile_cnt   <= '0;
        drain_cnt  <= '0;
      end else if (w_fire || x_fire) begin
        beat_cnt <= beat_last ? '0 : (beat_cnt + CNT_ONE);
        if (x_fire && beat_last) begin
          tile_cnt <= tile_cnt + CNT_ONE;
        end
      end else if (state == DRAIN) begin
        drain_cnt <= done ? '0 : (drain_cnt + DRAIN_ONE);
      end
    end
  end

  // Output vector register; bubbles clear data and flags but keep the last type seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_words <= '0;
      out_val   <= 1'b0;
      out_type  <= TYPE_X;
      out_last  <= 1'b0;
    end else if (clk_en) begin
      if (w_fire) begin
        out_words <= w_words;
        out_val   <= 1'b1;
        out_type  <= TYPE_W;
        out_last  <= beat_last;
      end else if (x_fire) begin
        out_words <= x_words;
        out_val   <= 1'b1;
        out_type  <= TYPE_X;
        out_last  <= beat_last;
      end else begin
        out_words <= '0;
        out_val   <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  assign sched_data_out = {out_words, out_val, out_type, out_last};
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_sys_arr_sched.sv
// Directed testbench for sys_arr_sched: N=4 words of 8 bits, DRAIN_CYC=32.
// Each cycle index r counts clock periods from the start of a scenario; sources
// drive A000_0000|r on the weight side and B000_0000|r on the activation side.
module tb_sys_arr_sched;

  localparam int   N     = 4;
  localparam int   WL    = 8;
  localparam int   DW    = N * WL;
  localparam int   AW    = 16;
  localparam int   DRAIN = 32;
  localparam logic TW    = 1'b1;
  localparam logic TX    = 1'b0;

  logic          clk;
  logic          rst_n;
  logic          clk_en;
  logic          start;
  logic [AW-1:0] cfg_act_len;
  logic [AW-1:0] cfg_tile_cnt;
  logic [DW-1:0] w_words;
  logic          w_val;
  logic          w_rdy;
  logic [DW-1:0] x_words;
  logic          x_val;
  logic          x_rdy;
  logic [DW+2:0] sched_data_out;
  logic          busy;
  logic          done;
  logic          cfg_err;

  int checks = 0;
  int passes = 0;

  logic          x_bubble = 1'b0;
  logic [AW-1:0] m_len    = 16'd3;

  logic [DW+2:0] log_out  [0:127];
  logic          log_busy [0:127];
  logic          log_done [0:127];
  logic          log_err  [0:127];
  logic          log_rdy  [0:127];
  logic          log_en   [0:127];

  sys_arr_sched #(
    .VECT_SIZE      (N),
    .ARITH_WORD_LEN (WL),
    .ACT_LEN_WDT    (AW),
    .DRAIN_CYC      (DRAIN),
    .TYPE_W         (TW),
    .TYPE_X         (TX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .start          (start),
    .cfg_act_len    (cfg_act_len),
    .cfg_tile_cnt   (cfg_tile_cnt),
    .w_words        (w_words),
    .w_val          (w_val),
    .w_rdy          (w_rdy),
    .x_words        (x_words),
    .x_val          (x_val),
    .x_rdy          (x_rdy),
    .sched_data_out (sched_data_out),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW+2:0] beat(input logic [DW-1:0] w, input logic t, input logic l);
    return {w, 1'b1, t, l};
  endfunction

  function automatic logic [DW+2:0] bubble(input logic t);
    return {{DW{1'b0}}, 1'b0, t, 1'b0};
  endfunction

  function automatic int count_done(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (log_done[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int first_done(input int n);
    for (int i = 0; i < n; i++) if (log_done[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_busy(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (log_busy[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_err(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (log_err[i] === 1'b1) c++;
    return c;
  endfunction

  // One clock period: drive source words for index r, sample, then advance to edge+1.
  task automatic clk_cycle(input int r);
    w_words = 32'hA000_0000 | 32'(r);
    x_words = 32'hB000_0000 | 32'(r);
    x_val   = !(x_bubble && ((r % 3) == 2));
    #1;
    log_out[r]  = sched_data_out;
    log_busy[r] = busy;
    log_done[r] = done;
    log_err[r]  = cfg_err;
    log_rdy[r]  = w_rdy | x_rdy;
    log_en[r]   = clk_en;
    @(posedge clk);
    #1;
  endtask

  // A run with start at r=0, optional clk_en low window and an optional start while busy.
  task automatic run(input int ncyc, input int en_lo, input int en_hi, input int busy_start);
    for (int r = 0; r < ncyc; r++) begin
      start       = (r == 0) || (r == busy_start);
      cfg_act_len = (r == busy_start) ? '0 : m_len;
      clk_en      = !((r >= en_lo) && (r <= en_hi));
      clk_cycle(r);
    end
    start       = 1'b0;
    cfg_act_len = m_len;
    clk_en      = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; w_val = 1'b1; x_val = 1'b1;
    cfg_act_len = m_len; cfg_tile_cnt = 16'd1; w_words = '0; x_words = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sched_data_out !== bubble(TX))
      $display("[TB] FAIL reset_out: got %h expected %h", sched_data_out, bubble(TX));
    else passes++;
    checks++;
    if ({busy, done, cfg_err, w_rdy, x_rdy} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, cfg_err, w_rdy, x_rdy});
    else passes++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, w_rdy, x_rdy} !== 3'b0)
      $display("[TB] FAIL idle_after_reset: got %b expected 000", {busy, w_rdy, x_rdy});
    else passes++;
  endtask

  task automatic test_single_tile();
    logic [DW+2:0] exp;
    m_len = 16'd3; cfg_tile_cnt = 16'd1; x_bubble = 1'b0;
    run(50, -1, -1, -1);
    checks++;
    if ({log_busy[0], log_err[0]} !== 2'b00)
      $display("[TB] FAIL single_start_cycle: got busy/err %b expected 00", {log_busy[0], log_err[0]});
    else passes++;
    checks++;
    if ({log_busy[1], log_rdy[1]} !== 2'b11)
      $display("[TB] FAIL single_first_ready: got busy/rdy %b expected 11", {log_busy[1], log_rdy[1]});
    else passes++;
    for (int i = 0; i < 7; i++) begin
      exp = (i < 4) ? beat(32'hA000_0000 | 32'(i + 1), TW, i == 3)
                    : beat(32'hB000_0000 | 32'(i + 1), TX, i == 6);
      checks++;
      if (log_out[2 + i] !== exp)
        $display("[TB] FAIL single_beat%0d: got %h expected %h", i + 1, log_out[2 + i], exp);
      else passes++;
    end
    checks++;
    if (log_out[9] !== bubble(TX))
      $display("[TB] FAIL single_after_last: got %h expected %h", log_out[9], bubble(TX));
    else passes++;
    checks++;
    if ((count_done(50) !== 1) || (first_done(50) !== 39))
      $display("[TB] FAIL single_done: got count %0d at %0d expected 1 at 39", count_done(50), first_done(50));
    else passes++;
    checks++;
    if ((count_busy(0, 49) !== 39) || (log_busy[39] !== 1'b1) || (log_busy[40] !== 1'b0))
      $display("[TB] FAIL single_busy: got %0d cycles expected 39 (t+1..t+39)", count_busy(0, 49));
    else passes++;
  endtask

  task automatic test_two_tiles_bubbles();
    int nb;
    int viol;
    logic seen;
    logic prev_type;
    logic [31:0] lastv;
    logic [31:0] typev;
    m_len = 16'd5; cfg_tile_cnt = 16'd2; x_bubble = 1'b1;
    run(80, -1, -1, -1);
    x_bubble = 1'b0;
    nb = 0; viol = 0; seen = 1'b0; prev_type = TX; lastv = '0; typev = '0;
    for (int r = 0; r < 80; r++) begin
      if (log_out[r][2] === 1'b1) begin
        if (nb < 32) begin
          lastv[nb] = log_out[r][0];
          typev[nb] = log_out[r][1];
        end
        nb++;
        seen = 1'b1;
        prev_type = log_out[r][1];
      end else if (seen && (log_out[r] !== bubble(prev_type))) begin
        viol++;
      end
    end
    checks++;
    if (nb !== 18) $display("[TB] FAIL two_tile_beats: got %0d expected 18", nb);
    else passes++;
    checks++;
    if (lastv !== 32'h0002_1108)
      $display("[TB] FAIL two_tile_last_pos: got %h expected 00021108", lastv);
    else passes++;
    checks++;
    if (typev !== 32'h0000_1E0F)
      $display("[TB] FAIL two_tile_types: got %h expected 00001e0f", typev);
    else passes++;
    checks++;
    if (viol !== 0) $display("[TB] FAIL two_tile_bubble_hold: got %0d bad bubbles expected 0", viol);
    else passes++;
    checks++;
    if (log_out[9] !== bubble(TX))
      $display("[TB] FAIL two_tile_x_bubble: got %h expected %h", log_out[9], bubble(TX));
    else passes++;
    checks++;
    if (log_out[6] !== bubble(TW))
      $display("[TB] FAIL two_tile_w_bubble: got %h expected %h", log_out[6], bubble(TW));
    else passes++;
    checks++;
    if ((count_done(80) !== 1) || (first_done(80) !== 56))
      $display("[TB] FAIL two_tile_done: got count %0d at %0d expected 1 at 56", count_done(80), first_done(80));
    else passes++;
  endtask

  task automatic test_clk_en_gating();
    int nb;
    int rdy_hi;
    m_len = 16'd3; cfg_tile_cnt = 16'd1; x_bubble = 1'b0;
    run(60, 6, 8, -1);
    rdy_hi = 0;
    for (int r = 6; r <= 8; r++) if (log_rdy[r] !== 1'b0 || log_done[r] !== 1'b0) rdy_hi++;
    checks++;
    if (rdy_hi !== 0) $display("[TB] FAIL gate_ready_low: got %0d cycles with ready/done expected 0", rdy_hi);
    else passes++;
    for (int r = 6; r <= 9; r++) begin
      checks++;
      if (log_out[r] !== beat(32'hB000_0005, TX, 1'b0))
        $display("[TB] FAIL gate_frozen_r%0d: got %h expected %h", r, log_out[r], beat(32'hB000_0005, TX, 1'b0));
      else passes++;
    end
    checks++;
    if (log_out[10] !== beat(32'hB000_0009, TX, 1'b0))
      $display("[TB] FAIL gate_resume: got %h expected %h", log_out[10], beat(32'hB000_0009, TX, 1'b0));
    else passes++;
    checks++;
    if (log_out[11] !== beat(32'hB000_000A, TX, 1'b1))
      $display("[TB] FAIL gate_last: got %h expected %h", log_out[11], beat(32'hB000_000A, TX, 1'b1));
    else passes++;
    nb = 0;
    for (int r = 1; r < 60; r++) if (log_out[r][2] === 1'b1 && log_en[r - 1] === 1'b1) nb++;
    checks++;
    if (nb !== 7) $display("[TB] FAIL gate_beats: got %0d expected 7", nb);
    else passes++;
    checks++;
    if ((count_done(60) !== 1) || (first_done(60) !== 42))
      $display("[TB] FAIL gate_done: got count %0d at %0d expected 1 at 42", count_done(60), first_done(60));
    else passes++;
  endtask

  task automatic test_cfg_error();
    int vals;
    for (int r = 0; r < 10; r++) begin
      start        = (r == 0) || (r == 4);
      cfg_act_len  = (r == 0) ? 16'd0 : 16'd3;
      cfg_tile_cnt = (r == 4) ? 16'd0 : 16'd1;
      clk_cycle(r);
    end
    start = 1'b0; cfg_act_len = m_len; cfg_tile_cnt = 16'd1;
    checks++;
    if ({log_err[0], log_err[4]} !== 2'b11)
      $display("[TB] FAIL cfg_err_pulses: got %b expected 11", {log_err[0], log_err[4]});
    else passes++;
    checks++;
    if (count_err(10) !== 2) $display("[TB] FAIL cfg_err_count: got %0d expected 2", count_err(10));
    else passes++;
    vals = 0;
    for (int r = 0; r < 10; r++) if (log_busy[r] !== 1'b0 || log_out[r][2] !== 1'b0) vals++;
    checks++;
    if (vals !== 0) $display("[TB] FAIL cfg_err_quiet: got %0d busy/valid cycles expected 0", vals);
    else passes++;
  endtask

  task automatic test_reset_mid_run();
    m_len = 16'd3; cfg_tile_cnt = 16'd1; cfg_act_len = m_len; x_bubble = 1'b0;
    start = 1'b1;
    clk_cycle(0);
    start = 1'b0;
    clk_cycle(1);
    w_words = 32'hA000_0002;
    x_words = 32'hB000_0002;
    #1;
    checks++;
    if (sched_data_out !== beat(32'hA000_0001, TW, 1'b0))
      $display("[TB] FAIL midrst_before: got %h expected %h", sched_data_out, beat(32'hA000_0001, TW, 1'b0));
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sched_data_out !== bubble(TX))
      $display("[TB] FAIL midrst_out: got %h expected %h", sched_data_out, bubble(TX));
    else passes++;
    checks++;
    if ({busy, done, cfg_err, w_rdy, x_rdy} !== 5'b0)
      $display("[TB] FAIL midrst_flags: got %b expected 00000", {busy, done, cfg_err, w_rdy, x_rdy});
    else passes++;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(50, -1, -1, -1);
    checks++;
    if (log_out[2] !== beat(32'hA000_0001, TW, 1'b0))
      $display("[TB] FAIL restart_first: got %h expected %h", log_out[2], beat(32'hA000_0001, TW, 1'b0));
    else passes++;
    checks++;
    if (log_out[5] !== beat(32'hA000_0004, TW, 1'b1))
      $display("[TB] FAIL restart_w_last: got %h expected %h", log_out[5], beat(32'hA000_0004, TW, 1'b1));
    else passes++;
    checks++;
    if (log_out[8] !== beat(32'hB000_0007, TX, 1'b1))
      $display("[TB] FAIL restart_x_last: got %h expected %h", log_out[8], beat(32'hB000_0007, TX, 1'b1));
    else passes++;
    checks++;
    if (first_done(50) !== 39) $display("[TB] FAIL restart_done: got %0d expected 39", first_done(50));
    else passes++;
  endtask

  task automatic test_start_while_busy();
    m_len = 16'd3; cfg_tile_cnt = 16'd1; x_bubble = 1'b0;
    run(60, -1, -1, 20);
    checks++;
    if (count_err(60) !== 0) $display("[TB] FAIL busy_start_err: got %0d expected 0", count_err(60));
    else passes++;
    checks++;
    if ((count_done(60) !== 1) || (first_done(60) !== 39))
      $display("[TB] FAIL busy_start_done: got count %0d at %0d expected 1 at 39", count_done(60), first_done(60));
    else passes++;
    checks++;
    if (count_busy(40, 59) !== 0)
      $display("[TB] FAIL busy_start_idle: got %0d busy cycles expected 0", count_busy(40, 59));
    else passes++;
  endtask

  // Scenario sequence, then the summary.
  initial begin
    test_reset();
    test_single_tile();
    test_two_tiles_bubbles();
    test_clk_en_gating();
    test_cfg_error();
    test_reset_mid_run();
    test_start_while_busy();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
